wall_generator: RTL and testbench

WALL_GENERATOR -- requirements
Module: wall_generator

---
 rtl/wall_generator.sv | 131 +++++++++++++
 tb/tb_wall_generator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wall_generator.sv
// rtl/wall_generator.sv - approaching wall with a rectangular hole, depth-shaded RGB565 pixel output
// Wall launches on start, steps one depth unit every FRAMES_PER_STEP frames, and flags collision at depth 0.
module wall_generator #(
   parameter int          ACTIVE_H_PIXELS = 1280,
   parameter int          ACTIVE_LINES    = 720,
   parameter int          START_DEPTH     = 255,
   parameter int          FRAMES_PER_STEP = 2,
   parameter logic [15:0] WALL_RGB        = 16'hF800
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] h_count_in,
   input  logic [9:0]  v_count_in,
   input  logic        new_frame_in,
   input  logic        start_in,
   input  logic [10:0] hole_x_in,
   input  logic [10:0] hole_w_in,
   input  logic [9:0]  hole_y_in,
   input  logic [9:0]  hole_h_in,
   output logic        is_wall,
   output logic [15:0] wall_color,
   output logic [7:0]  wall_depth,
   output logic        wall_active,
   output logic        collision_check
);

   typedef enum logic [1:0] {IDLE, APPROACH, CHECK} state_t;

   localparam logic [11:0] H_LIMIT    = 12'(ACTIVE_H_PIXELS);
   localparam logic [10:0] V_LIMIT    = 11'(ACTIVE_LINES);
   localparam logic [7:0]  START_D    = 8'(START_DEPTH);
   localparam logic [15:0] FRAME_LAST = 16'(FRAMES_PER_STEP - 1);
   localparam logic [4:0]  BASE_R     = WALL_RGB[15:11];
   localparam logic [5:0]  BASE_G     = WALL_RGB[10:5];
   localparam logic [4:0]  BASE_B     = WALL_RGB[4:0];

   state_t      state;
   logic [15:0] frame_cnt;
   logic [10:0] hole_x, hole_w;
   logic [9:0]  hole_y, hole_h;
   logic        pulse_pending;

   logic [11:0] h_ext, h_end;
   logic [10:0] v_ext, v_end;
   logic        inside_hole, in_area, pix_wall;
   logic [1:0]  shift;
   logic [15:0] shaded;

   // hole edges are widened by one bit so x+w never wraps back into the screen
   always_comb begin
      h_ext       = {1'b0, h_count_in};
      v_ext       = {1'b0, v_count_in};
      h_end       = {1'b0, hole_x} + {1'b0, hole_w};
      v_end       = {1'b0, hole_y} + {1'b0, hole_h};
      inside_hole = (h_ext >= {1'b0, hole_x}) && (h_ext < h_end) &&
                    (v_ext >= {1'b0, hole_y}) && (v_ext < v_end);
      in_area     = (h_ext < H_LIMIT) && (v_ext < V_LIMIT);
      pix_wall    = wall_active && in_area && !inside_hole;
   end

   always_comb begin
      shift = 2'd0;
      if (wall_depth >= 8'd192)
         shift = 2'd2;
      else if (wall_depth >= 8'd128)
         shift = 2'd1;
      shaded = {BASE_R >> shift, BASE_G >> shift, BASE_B >> shift};
   end

   // collision_check fires one cycle after depth lands on 0, via pulse_pending
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state           <= IDLE;
         frame_cnt       <= 16'd0;
         hole_x          <= 11'd0;
         hole_w          <= 11'd0;
         hole_y          <= 10'd0;
         hole_h          <= 10'd0;
         pulse_pending   <= 1'b0;
         is_wall         <= 1'b0;
         wall_color      <= 16'h0000;
         wall_depth      <= 8'd0;
         wall_active     <= 1'b0;
         collision_check <= 1'b0;
      end else begin
         is_wall         <= pix_wall;
         wall_color      <= pix_wall ? shaded : 16'h0000;
         collision_check <= pulse_pending;
         pulse_pending   <= 1'b0;
         case (state)
            IDLE: begin
               if (start_in) begin
                  hole_x      <= hole_x_in;
                  hole_w      <= hole_w_in;
                  hole_y      <= hole_y_in;
                  hole_h      <= hole_h_in;
                  wall_depth  <= START_D;
                  frame_cnt   <= 16'd0;
                  wall_active <= 1'b1;
                  state       <= APPROACH;
               end
            end
            APPROACH: begin
               if (new_frame_in) begin
                  if (frame_cnt == FRAME_LAST) begin
                     frame_cnt <= 16'd0;
                     if (wall_depth <= 8'd1) begin
                        wall_depth    <= 8'd0;
                        pulse_pending <= 1'b1;
                        state         <= CHECK;
                     end else begin
                        wall_depth <= wall_depth - 8'd1;
                     end
                  end else begin
                     frame_cnt <= frame_cnt + 16'd1;
                  end
               end
            end
            CHECK: begin
               if (new_frame_in) begin
                  wall_depth  <= 8'd0;
                  wall_active <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wall_generator.sv
// tb/tb_wall_generator.sv - directed and randomized checks of wall_generator against a frame-count model
module tb_wall_generator;

   localparam int H_PIX = 1280;
   localparam int V_LIN = 720;
   localparam int START = 255;
   localparam int FPS   = 2;
   localparam int RGB   = 16'hF800;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [10:0] h = 11'd0;
   logic [9:0]  v = 10'd0;
   logic        nf = 1'b0;
   logic        start = 1'b0;
   logic [10:0] hx = 11'd0, hw = 11'd0;
   logic [9:0]  hy = 10'd0, hh = 10'd0;
   logic        is_wall, wall_active, collision_check;
   logic [15:0] wall_color;
   logic [7:0]  wall_depth;

   int passed = 0;
   int total  = 0;

   // model: depth is derived from how many frame pulses the wall has seen
   bit m_flight = 0, m_check = 0, m_pend = 0, m_coll = 0;
   int m_pulses = 0, m_depth = 0;
   int g_x = 0, g_w = 0, g_y = 0, g_h = 0;

   wall_generator dut (
      .clk_in(clk), .rst_in(rst), .h_count_in(h), .v_count_in(v),
      .new_frame_in(nf), .start_in(start),
      .hole_x_in(hx), .hole_w_in(hw), .hole_y_in(hy), .hole_h_in(hh),
      .is_wall(is_wall), .wall_color(wall_color), .wall_depth(wall_depth),
      .wall_active(wall_active), .collision_check(collision_check)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
   endtask

   function automatic int shade(input int d);
      int s;
      s = (d >= 192) ? 2 : (d >= 128) ? 1 : 0;
      return ((((RGB >> 11) & 31) >> s) << 11) | ((((RGB >> 5) & 63) >> s) << 5) | ((RGB & 31) >> s);
   endfunction

   task automatic tick();
      bit ew;
      int ec;
      ew = rst && m_flight && (int'(h) < H_PIX) && (int'(v) < V_LIN) &&
           !((int'(h) >= g_x) && (int'(h) < g_x + g_w) && (int'(v) >= g_y) && (int'(v) < g_y + g_h));
      ec = ew ? shade(m_depth) : 0;
      @(posedge clk);
      if (!rst) begin
         m_flight = 0; m_check = 0; m_pend = 0; m_coll = 0;
         m_pulses = 0; m_depth = 0; g_x = 0; g_w = 0; g_y = 0; g_h = 0;
      end else begin
         m_coll = m_pend;
         m_pend = 0;
         if (!m_flight) begin
            if (start) begin
               m_flight = 1; m_check = 0; m_pulses = 0; m_depth = START;
               g_x = int'(hx); g_w = int'(hw); g_y = int'(hy); g_h = int'(hh);
            end
         end else if (!m_check) begin
            if (nf) begin
               m_pulses++;
               m_depth = START - m_pulses / FPS;
               if (m_depth <= 0) begin
                  m_depth = 0; m_check = 1; m_pend = 1;
               end
            end
         end else if (nf) begin
            m_flight = 0; m_check = 0; m_depth = 0;
         end
      end
      #1;
      chk("is_wall", int'(is_wall), int'(ew));
      chk("wall_color", int'(wall_color), ec);
      chk("wall_depth", int'(wall_depth), m_depth);
      chk("wall_active", int'(wall_active), int'(m_flight));
      chk("collision_check", int'(collision_check), int'(m_coll));
   endtask

   initial begin
      int ncoll;
      repeat (3) tick();
      chk("reset_depth", int'(wall_depth), 0);
      chk("reset_active", int'(wall_active), 0);
      rst = 1'b1;
      tick();

      start = 1'b1; hx = 11'd100; hy = 10'd100; hw = 11'd200; hh = 10'd150;
      tick();
      start = 1'b0;
      chk("start_depth", int'(wall_depth), 255);
      chk("start_active", int'(wall_active), 1);

      h = 11'd150; v = 10'd150; tick();
      chk("hole_center", int'(is_wall), 0);
      h = 11'd99; tick();
      chk("hole_left_out", int'(is_wall), 1);
      chk("shade_255", int'(wall_color), 16'h3800);
      h = 11'd300; tick();
      chk("hole_right_excl", int'(is_wall), 1);
      h = 11'd1280; tick();
      chk("h_limit", int'(is_wall), 0);

      start = 1'b1; hx = 11'd0; hw = 11'd1280; hy = 10'd0; hh = 10'd720; h = 11'd99;
      tick();
      start = 1'b0;
      tick();
      chk("restart_ignored_geom", int'(is_wall), 1);
      chk("restart_ignored_depth", int'(wall_depth), 255);

      ncoll = 0;
      for (int i = 1; i <= 510; i++) begin
         nf = 1'b1; tick();
         nf = 1'b0;
         if (i == 2) chk("depth_after_2", int'(wall_depth), 254);
         if (i == 510) chk("depth_zero", int'(wall_depth), 0);
         if (i < 510) ncoll += int'(collision_check);
         tick();
         if (i < 510) ncoll += int'(collision_check);
         if (i == 210) chk("shade_150", int'(wall_color), 16'h7800);
         if (i == 410) chk("shade_50", int'(wall_color), 16'hF800);
         if (i == 510) chk("collision_pulse", int'(collision_check), 1);
      end
      chk("no_early_collision", ncoll, 0);
      tick();
      chk("collision_single", int'(collision_check), 0);
      chk("check_active", int'(wall_active), 1);
      nf = 1'b1; tick(); nf = 1'b0;
      chk("check_to_idle", int'(wall_active), 0);

      start = 1'b1; nf = 1'b1; tick();
      start = 1'b0; nf = 1'b0;
      chk("start_wins_depth", int'(wall_depth), 255);
      nf = 1'b1; tick(); nf = 1'b0; tick();
      chk("one_pulse_hold", int'(wall_depth), 255);
      nf = 1'b1; tick(); nf = 1'b0; tick();
      chk("two_pulse_step", int'(wall_depth), 254);
      for (int i = 0; i < 108; i++) begin
         nf = 1'b1; tick(); nf = 1'b0; tick();
      end
      chk("depth_200", int'(wall_depth), 200);
      rst = 1'b0; start = 1'b1; tick();
      chk("rst_depth", int'(wall_depth), 0);
      chk("rst_active", int'(wall_active), 0);
      chk("rst_is_wall", int'(is_wall), 0);
      chk("rst_color", int'(wall_color), 0);
      rst = 1'b1; start = 1'b0; tick();
      chk("rst_start_ignored", int'(wall_active), 0);
      start = 1'b1; tick(); start = 1'b0;
      chk("reload_depth", int'(wall_depth), 255);

      for (int c = 0; c < 15000; c++) begin
         rst   = ($urandom_range(0, 399) != 0);
         start = ($urandom_range(0, 29) == 0);
         nf    = ($urandom_range(0, 2) == 0);
         h     = 11'($urandom_range(0, 2047));
         v     = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) == 0) begin
            hx = 11'($urandom_range(0, 2047)); hw = 11'($urandom_range(0, 2047));
            hy = 10'($urandom_range(0, 1023)); hh = 10'($urandom_range(0, 1023));
         end else begin
            hx = 11'($urandom_range(0, 1300)); hw = 11'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 600));
            hy = 10'($urandom_range(0, 740));  hh = 10'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 400));
         end
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
